// File: rtl/spi_byte_master.sv
// SPI mode-0 byte master: one byte per start, MSB first, optional CS_n hold across bytes.
// Latency: CS_SETUP (first byte only) + 16*CLK_DIV + CS_HOLD (last byte only) clocks to done.
// Backpressure: start is ignored while busy; the caller waits for done before the next start.
module spi_byte_master #(
  parameter int CLK_DIV  = 2,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] tx_byte,
  input  logic       last,
  output logic       busy,
  output logic       done,
  output logic [7:0] rx_byte,
  output logic       spi_cs_n,
  output logic       spi_sck,
  output logic       spi_mosi,
  input  logic       spi_miso
);

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

  localparam logic [7:0] DIV_M1   = 8'(CLK_DIV - 1);
  localparam logic [7:0] SETUP_M1 = 8'(CS_SETUP - 1);
  localparam logic [7:0] HOLD_M1  = 8'(CS_HOLD - 1);

  state_t     state;
  logic [7:0] half_cnt;  // also times the SETUP and HOLD phases
  logic [3:0] bit_cnt;
  logic [7:0] tx_sr;
  logic [7:0] rx_sr;
  logic       last_q;

  // Single FSM: every output is a register updated here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      half_cnt <= '0;
      bit_cnt  <= '0;
      tx_sr    <= '0;
      rx_sr    <= '0;
      last_q   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      rx_byte  <= '0;
      spi_cs_n <= 1'b1;
      spi_sck  <= 1'b0;
      spi_mosi <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            tx_sr    <= tx_byte;
            last_q   <= last;
            busy     <= 1'b1;
            half_cnt <= '0;
            bit_cnt  <= '0;
            if (spi_cs_n) begin
              // Fresh selection: give the slave setup time before clocking.
              state    <= SETUP;
              spi_cs_n <= 1'b0;
            end else begin
              // CS_n still held from the previous byte: clock immediately.
              state    <= SHIFT;
              spi_mosi <= tx_byte[7];
            end
          end
        end
        SETUP: begin
          if (half_cnt == SETUP_M1) begin
            state    <= SHIFT;
            half_cnt <= '0;
            spi_mosi <= tx_sr[7];
          end else begin
            half_cnt <= half_cnt + 8'd1;
          end
        end
        SHIFT: begin
          if (half_cnt == DIV_M1) begin
            half_cnt <= '0;
            if (!spi_sck) begin
              // Rising edge: sample MISO.
              spi_sck <= 1'b1;
              rx_sr   <= {rx_sr[6:0], spi_miso};
            end else begin
              // Falling edge: next MOSI bit, or leave after the 8th period.
              spi_sck <= 1'b0;
              if (bit_cnt == 4'd7) begin
                bit_cnt <= '0;
                if (last_q) begin
                  state <= HOLD;
                end else begin
                  state   <= IDLE;
                  done    <= 1'b1;
                  busy    <= 1'b0;
                  rx_byte <= rx_sr;
                end
              end else begin
                bit_cnt  <= bit_cnt + 4'd1;
                tx_sr    <= {tx_sr[6:0], 1'b0};
                spi_mosi <= tx_sr[6];
              end
            end
          end else begin
            half_cnt <= half_cnt + 8'd1;
          end
        end
        HOLD: begin
          if (half_cnt == HOLD_M1) begin
            state    <= IDLE;
            half_cnt <= '0;
            spi_cs_n <= 1'b1;
            spi_mosi <= 1'b0;
            done     <= 1'b1;
            busy     <= 1'b0;
            rx_byte  <= rx_sr;
          end else begin
            half_cnt <= half_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
